// File: rtl/alg_seq_ctrl_pkg.sv
// Shared types for the EX-stage algebraic-unit sequencer.
//   lc3b_word   : 16-bit datapath word
//   op_none     : extended-op code that leaves the algebraic unit idle
//   op_mul      : extended-op code for a multiply
//   alg_state_t : sequencer states IDLE / BUSY / DONE
package alg_seq_ctrl_pkg;

    typedef logic [15:0] lc3b_word;

    localparam logic [2:0] op_none = 3'b000;
    localparam logic [2:0] op_mul  = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alg_state_t;

endpackage

// File: rtl/alg_seq_ctrl.sv
// Issue/writeback sequencer sitting in front of the multi-cycle algebraic unit.
// Latches a multiply request, holds the operands steady on the unit while it
// computes for LATENCY cycles, stalls the upstream pipeline meanwhile, captures
// the product into result registers and pulses res_valid for one cycle.
//
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/op/a/b      : request from the EX stage
//   flush                 : squash of the instruction currently in EX
//   stall                 : hold pipeline stages upstream of EX
//   res_valid             : one-cycle pulse, res_hi/res_lo hold a new result
//   res_hi, res_lo        : captured result words
//   unit_opA/opB/op       : operands and op code driven to the algebraic unit
//   unit_hi, unit_lo      : product returned by the algebraic unit
module alg_seq_ctrl
    import alg_seq_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 4   // legal range 2..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic        res_valid,
    output logic [15:0] res_hi,
    output logic [15:0] res_lo,
    output logic [15:0] unit_opA,
    output logic [15:0] unit_opB,
    output logic [2:0]  unit_op,
    input  logic [15:0] unit_hi,
    input  logic [15:0] unit_lo
);

    localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

    alg_state_t state_q, state_d;
    logic [3:0] count_q, count_d;
    lc3b_word   opa_q, opa_d;
    lc3b_word   opb_q, opb_d;
    logic [2:0] op_q, op_d;
    lc3b_word   res_hi_q, res_hi_d;
    lc3b_word   res_lo_q, res_lo_d;

    logic accept;

    // A flush squashes whatever EX is presenting, so it blocks acceptance.
    assign accept = req_valid && (req_op == op_mul) && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= op_none;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        op_d      = op_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        stall     = 1'b0;
        res_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    opa_d   = req_a;
                    opb_d   = req_b;
                    op_d    = req_op;
                    count_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (count_q == LAST_COUNT) begin
                    res_hi_d = unit_hi;
                    res_lo_d = unit_lo;
                    state_d  = DONE;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            DONE: begin
                // The pipeline advances here; a new mul may chain straight into BUSY.
                res_valid = 1'b1;
                if (accept) begin
                    opa_d   = req_a;
                    opb_d   = req_b;
                    op_d    = req_op;
                    count_d = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_hi   = res_hi_q;
    assign res_lo   = res_lo_q;
    assign unit_opA = opa_q;
    assign unit_opB = opb_q;
    // Only BUSY drives a real op, so the unit never counts while idle.
    assign unit_op  = (state_q == BUSY) ? op_q : op_none;

endmodule

// File: tb/tb_alg_seq_ctrl.sv
// Directed bench for alg_seq_ctrl with an unsigned 16x16 multiplier model
// standing in for the algebraic unit.
module tb_alg_seq_ctrl;
    import alg_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        flush;
    logic        stall;
    logic        res_valid;
    logic [15:0] res_hi;
    logic [15:0] res_lo;
    logic [15:0] unit_opA;
    logic [15:0] unit_opB;
    logic [2:0]  unit_op;
    logic [15:0] unit_hi;
    logic [15:0] unit_lo;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    alg_seq_ctrl #(.LATENCY(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .stall     (stall),
        .res_valid (res_valid),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .unit_opA  (unit_opA),
        .unit_opB  (unit_opB),
        .unit_op   (unit_op),
        .unit_hi   (unit_hi),
        .unit_lo   (unit_lo)
    );

    logic [31:0] product;
    always_comb begin
        product = 32'(unit_opA) * 32'(unit_opB);
        unit_hi = product[31:16];
        unit_lo = product[15:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = op_none;
        req_a = '0; req_b = '0; flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        settle();
        chk("rst_stall",   32'(stall),     32'h0);
        chk("rst_rvalid",  32'(res_valid), 32'h0);
        chk("rst_hi",      32'(res_hi),    32'h0);
        chk("rst_lo",      32'(res_lo),    32'h0);
        chk("rst_opA",     32'(unit_opA),  32'h0);
        chk("rst_opB",     32'(unit_opB),  32'h0);
        chk("rst_uop",     32'(unit_op),   32'(op_none));

        // 1: single mul 3*5, stall T..T+4, res_valid at T+5
        tick();
        req_valid = 1'b1; req_op = op_mul; req_a = 16'h0003; req_b = 16'h0005;
        settle();
        chk("t1_stall_T", 32'(stall),   32'h1);
        chk("t1_uop_T",   32'(unit_op), 32'(op_none));
        tick();
        req_valid = 1'b0; req_a = 16'hDEAD; req_b = 16'hBEEF;
        settle();
        for (int i = 1; i <= 4; i++) begin
            chk("t1_busy_stall", 32'(stall),     32'h1);
            chk("t1_busy_rv",    32'(res_valid), 32'h0);
            chk("t1_busy_uop",   32'(unit_op),   32'(op_mul));
            chk("t1_busy_opA",   32'(unit_opA),  32'h0003);
            chk("t1_busy_opB",   32'(unit_opB),  32'h0005);
            tick();
        end
        chk("t1_done_rv",    32'(res_valid), 32'h1);
        chk("t1_done_stall", 32'(stall),     32'h0);
        chk("t1_hi",         32'(res_hi),    32'h0000);
        chk("t1_lo",         32'(res_lo),    32'h000F);
        chk("t1_done_uop",   32'(unit_op),   32'(op_none));
        tick();
        chk("t1_idle_rv",    32'(res_valid), 32'h0);
        chk("t1_hold_lo",    32'(res_lo),    32'h000F);

        // 2: FFFF*FFFF unsigned, then 3: back-to-back 0x10*0x10 issued in DONE
        req_valid = 1'b1; req_op = op_mul; req_a = 16'hFFFF; req_b = 16'hFFFF;
        tick();
        req_valid = 1'b0; req_a = '0; req_b = '0;
        settle();
        for (int i = 1; i <= 4; i++) begin
            chk("t2_busy_opA", 32'(unit_opA), 32'hFFFF);
            chk("t2_busy_opB", 32'(unit_opB), 32'hFFFF);
            chk("t2_busy_uop", 32'(unit_op),  32'(op_mul));
            tick();
        end
        req_valid = 1'b1; req_op = op_mul; req_a = 16'h0010; req_b = 16'h0010;
        settle();
        chk("t2_done_rv", 32'(res_valid), 32'h1);
        chk("t2_hi",      32'(res_hi),    32'hFFFE);
        chk("t2_lo",      32'(res_lo),    32'h0001);
        tick();
        req_valid = 1'b0;
        settle();
        for (int i = 1; i <= 4; i++) begin
            chk("t3_busy_stall", 32'(stall),     32'h1);
            chk("t3_busy_rv",    32'(res_valid), 32'h0);
            chk("t3_busy_uop",   32'(unit_op),   32'(op_mul));
            chk("t3_busy_opA",   32'(unit_opA),  32'h0010);
            tick();
        end
        chk("t3_done_rv", 32'(res_valid), 32'h1);
        chk("t3_hi",      32'(res_hi),    32'h0000);
        chk("t3_lo",      32'(res_lo),    32'h0100);
        tick();

        // 4: flush at count==1, result registers keep 0x0000/0x0100
        req_valid = 1'b1; req_op = op_mul; req_a = 16'h0007; req_b = 16'h0009;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        settle();
        chk("t4_flush_stall", 32'(stall), 32'h1);
        tick();
        flush = 1'b0;
        settle();
        chk("t4_after_stall", 32'(stall),   32'h0);
        chk("t4_after_uop",   32'(unit_op), 32'(op_none));
        for (int i = 0; i < 6; i++) begin
            chk("t4_no_rv", 32'(res_valid), 32'h0);
            tick();
        end
        chk("t4_keep_hi", 32'(res_hi), 32'h0000);
        chk("t4_keep_lo", 32'(res_lo), 32'h0100);

        // 5: reset mid-BUSY, then 0x100*0x100 completes normally
        req_valid = 1'b1; req_op = op_mul; req_a = 16'h0002; req_b = 16'h0003;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("t5_stall",  32'(stall),     32'h0);
        chk("t5_rv",     32'(res_valid), 32'h0);
        chk("t5_hi",     32'(res_hi),    32'h0);
        chk("t5_lo",     32'(res_lo),    32'h0);
        chk("t5_opA",    32'(unit_opA),  32'h0);
        chk("t5_opB",    32'(unit_opB),  32'h0);
        chk("t5_uop",    32'(unit_op),   32'(op_none));
        req_valid = 1'b1; req_op = op_mul; req_a = 16'h0100; req_b = 16'h0100;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t5_done_rv", 32'(res_valid), 32'h1);
        chk("t5_new_hi",  32'(res_hi),    32'h0001);
        chk("t5_new_lo",  32'(res_lo),    32'h0000);
        tick();

        // 6: non-mul op never engages; flush blocks a mul in IDLE
        req_valid = 1'b1; req_op = 3'b010; req_a = 16'h1234; req_b = 16'h5678;
        settle();
        for (int i = 0; i < 6; i++) begin
            chk("t6_stall", 32'(stall),     32'h0);
            chk("t6_uop",   32'(unit_op),   32'(op_none));
            chk("t6_rv",    32'(res_valid), 32'h0);
            tick();
        end
        req_op = op_mul; flush = 1'b1;
        settle();
        chk("t6_flush_stall", 32'(stall), 32'h0);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        settle();
        chk("t6_flush_uop", 32'(unit_op), 32'(op_none));
        chk("t6_keep_lo",   32'(res_lo),  32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
